a_b_src: RTL and testbench

A_B_SRC -- requirements
Module: a_b_src

---
 rtl/a_b_src_if.sv | 24 ++
 rtl/a_b_src.sv | 88 ++++++++
 tb/tb_a_b_src.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/a_b_src_if.sv
// Upstream FIFO port and downstream credit link of a_b_src, grouped as one bundle.
interface a_b_src_if;
    logic [13:0] in_data;
    logic        in_vld;
    logic        in_rdy;
    logic [13:0] a_b_0;
    logic        a_b_1;
    logic [3:0]  b_a_0;
    logic        b_a_1;
    logic [3:0]  credit_cnt;
    logic        cr_err;

    // The credit source itself.
    modport master (
        input  in_data, in_vld, b_a_0, b_a_1,
        output in_rdy, a_b_0, a_b_1, credit_cnt, cr_err
    );

    // The surrounding environment (upstream producer plus downstream consumer).
    modport slave (
        output in_data, in_vld, b_a_0, b_a_1,
        input  in_rdy, a_b_0, a_b_1, credit_cnt, cr_err
    );
endinterface

// File: rtl/a_b_src.sv
// Credit-based source: buffers upstream words in a small FIFO and forwards one
// word per edge to the downstream consumer while credits remain.
module a_b_src #(
    parameter int unsigned CREDITS = 8,
    parameter int unsigned DEPTH   = 4
) (
    input  logic  clk,
    input  logic  rst,
    a_b_src_if.master bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [13:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    credit_q, credit_d;
    logic          err_q, err_d;
    logic [13:0]   out_data_q, out_data_d;
    logic          out_vld_q, out_vld_d;

    logic          push, pop;
    logic [4:0]    cr_sum;

    // Readiness depends only on registered count; a same-cycle pop never frees a full FIFO.
    assign bus.in_rdy     = (count_q != CW'(DEPTH));
    assign push           = bus.in_vld & bus.in_rdy;
    // Send uses the registered credit, so a return at zero credit only enables the next edge.
    assign pop            = (count_q != '0) && (credit_q != 4'd0);

    assign bus.a_b_0      = out_data_q;
    assign bus.a_b_1      = out_vld_q;
    assign bus.credit_cnt = credit_q;
    assign bus.cr_err     = err_q;

    // Next-state for FIFO bookkeeping, outgoing word, and credit accounting.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        out_vld_d  = pop;
        out_data_d = pop ? mem_q[rd_ptr_q] : out_data_q;

        // Credit never underflows: pop requires credit_q > 0. Max sum 15+15 fits in 5 bits.
        cr_sum     = {1'b0, credit_q} - {4'd0, pop} + (bus.b_a_1 ? {1'b0, bus.b_a_0} : 5'd0);
        err_d      = err_q;
        if (cr_sum > 5'(CREDITS)) begin
            credit_d = 4'(CREDITS);
            err_d    = 1'b1;
        end else begin
            credit_d = cr_sum[3:0];
        end
    end

    // Control and output registers, synchronously reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 4'(CREDITS);
            err_q      <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset needed.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_a_b_src.sv
module tb_a_b_src;
    localparam int unsigned CREDITS = 8;
    localparam int unsigned DEPTH   = 4;

    logic clk = 1'b0;
    logic rst;
    a_b_src_if bus ();

    a_b_src #(.CREDITS(CREDITS), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: a queue of pending words and a plain integer credit.
    logic [13:0] m_fifo[$];
    int          m_cred;
    bit          m_err;
    logic [13:0] m_ab0;
    bit          m_ab1;

    // Advance one edge: DUT via the clock, reference via the transfer rules.
    task automatic tick();
        bit rdy, push, send;
        int n;
        @(posedge clk);
        if (rst) begin
            m_fifo.delete();
            m_cred = CREDITS;
            m_err  = 0;
            m_ab0  = '0;
            m_ab1  = 0;
        end else begin
            rdy  = (m_fifo.size() != DEPTH);
            push = bus.in_vld && rdy;
            send = (m_fifo.size() > 0) && (m_cred > 0);
            if (send) begin
                m_ab0 = m_fifo.pop_front();
                m_ab1 = 1;
            end else begin
                m_ab1 = 0;
            end
            if (push) m_fifo.push_back(bus.in_data);
            n = m_cred - int'(send) + (bus.b_a_1 ? int'(bus.b_a_0) : 0);
            if (n > CREDITS) begin
                m_cred = CREDITS;
                m_err  = 1;
            end else begin
                m_cred = n;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst         = 0;
        bus.in_vld  = 0;
        bus.in_data = '0;
        bus.b_a_1   = 0;
        bus.b_a_0   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // Reset, then stream ten words with no credit returns; reports sends seen.
    task automatic fill10(output int sends);
        sends = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.in_vld  = 1;
            bus.in_data = 14'h100 + 14'(i);
            tick();
            sends += int'(bus.a_b_1);
        end
        bus.in_vld = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            sends += int'(bus.a_b_1);
        end
    endtask

    task automatic test_reset();
        bus.in_vld = 1; bus.in_data = 14'h3FFF; bus.b_a_1 = 1; bus.b_a_0 = 4'd5;
        rst = 1;
        tick();
        rst = 0;
        total++; if (bus.a_b_1 !== 1'b0) begin bad++; $display("FAIL reset_ab1 got=%b exp=0", bus.a_b_1); end
        total++; if (bus.a_b_0 !== 14'h0) begin bad++; $display("FAIL reset_ab0 got=%h exp=0", bus.a_b_0); end
        total++; if (bus.credit_cnt !== 4'd8) begin bad++; $display("FAIL reset_credit got=%0d exp=8", bus.credit_cnt); end
        total++; if (bus.cr_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.cr_err); end
        total++; if (bus.in_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", bus.in_rdy); end
    endtask

    task automatic test_single();
        do_reset();
        bus.in_vld = 1; bus.in_data = 14'h1A5;
        tick();
        bus.in_vld = 0;
        total++; if (bus.a_b_1 !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", bus.a_b_1); end
        tick();
        total++; if (bus.a_b_1 !== 1'b1) begin bad++; $display("FAIL single_vld got=%b exp=1", bus.a_b_1); end
        total++; if (bus.a_b_0 !== 14'h1A5) begin bad++; $display("FAIL single_data got=%h exp=1a5", bus.a_b_0); end
        total++; if (bus.credit_cnt !== 4'd7) begin bad++; $display("FAIL single_credit got=%0d exp=7", bus.credit_cnt); end
        tick();
        total++; if (bus.a_b_1 !== 1'b0) begin bad++; $display("FAIL single_oneshot got=%b exp=0", bus.a_b_1); end
        total++; if (bus.a_b_0 !== 14'h1A5) begin bad++; $display("FAIL single_hold got=%h exp=1a5", bus.a_b_0); end
    endtask

    task automatic test_back_to_back();
        int sends;
        fill10(sends);
        total++; if (sends != 8) begin bad++; $display("FAIL b2b_sends got=%0d exp=8", sends); end
        total++; if (bus.credit_cnt !== 4'd0) begin bad++; $display("FAIL b2b_credit got=%0d exp=0", bus.credit_cnt); end
        total++; if (bus.in_rdy !== 1'b1) begin bad++; $display("FAIL b2b_rdy2 got=%b exp=1", bus.in_rdy); end
        bus.in_vld = 1; bus.in_data = 14'h2AA;
        tick();
        total++; if (bus.in_rdy !== 1'b1) begin bad++; $display("FAIL b2b_rdy3 got=%b exp=1", bus.in_rdy); end
        bus.in_data = 14'h2AB;
        tick();
        total++; if (bus.in_rdy !== 1'b0) begin bad++; $display("FAIL b2b_rdy4 got=%b exp=0", bus.in_rdy); end
        // A held word while full must not be accepted.
        bus.in_data = 14'h2AC;
        tick();
        bus.in_vld = 0;
        total++; if (m_fifo.size() != 4 || bus.in_rdy !== 1'b0) begin
            bad++; $display("FAIL b2b_full_hold got=%b exp=0", bus.in_rdy);
        end
    endtask

    task automatic test_credit_return();
        int sends;
        fill10(sends);
        bus.b_a_1 = 1; bus.b_a_0 = 4'd2;
        tick();
        bus.b_a_1 = 0; bus.b_a_0 = 4'd0;
        total++; if (bus.credit_cnt !== 4'd2 || bus.a_b_1 !== 1'b0) begin
            bad++; $display("FAIL ret_credit got=%0d/%b exp=2/0", bus.credit_cnt, bus.a_b_1);
        end
        tick();
        total++; if (bus.a_b_1 !== 1'b1 || bus.a_b_0 !== 14'h108) begin
            bad++; $display("FAIL ret_send1 got=%b/%h exp=1/108", bus.a_b_1, bus.a_b_0);
        end
        tick();
        total++; if (bus.a_b_1 !== 1'b1 || bus.a_b_0 !== 14'h109 || bus.credit_cnt !== 4'd0) begin
            bad++; $display("FAIL ret_send2 got=%b/%h/%0d exp=1/109/0", bus.a_b_1, bus.a_b_0, bus.credit_cnt);
        end
        // Zero-count return is a no-op.
        bus.b_a_1 = 1; bus.b_a_0 = 4'd0;
        tick();
        bus.b_a_1 = 0;
        total++; if (bus.credit_cnt !== 4'd0) begin bad++; $display("FAIL ret_zero got=%0d exp=0", bus.credit_cnt); end
    endtask

    task automatic test_simul_send_return();
        do_reset();
        bus.in_vld = 1; bus.in_data = 14'h011;
        tick();
        bus.in_data = 14'h022;
        tick();
        bus.in_vld = 0;
        total++; if (bus.credit_cnt !== 4'd7) begin bad++; $display("FAIL simul_pre got=%0d exp=7", bus.credit_cnt); end
        bus.b_a_1 = 1; bus.b_a_0 = 4'd1;
        tick();
        bus.b_a_1 = 0; bus.b_a_0 = 4'd0;
        total++; if (bus.credit_cnt !== 4'd7 || bus.a_b_1 !== 1'b1 || bus.a_b_0 !== 14'h022) begin
            bad++; $display("FAIL simul_credit got=%0d/%b/%h exp=7/1/022", bus.credit_cnt, bus.a_b_1, bus.a_b_0);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.b_a_1 = 1; bus.b_a_0 = 4'd3;
        tick();
        bus.b_a_1 = 0; bus.b_a_0 = 4'd0;
        total++; if (bus.credit_cnt !== 4'd8 || bus.cr_err !== 1'b1) begin
            bad++; $display("FAIL ovf_set got=%0d/%b exp=8/1", bus.credit_cnt, bus.cr_err);
        end
        for (int i = 0; i < 5; i++) tick();
        total++; if (bus.cr_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.cr_err); end
        do_reset();
        total++; if (bus.cr_err !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", bus.cr_err); end
    endtask

    task automatic test_reset_flush();
        int sends;
        int stale;
        fill10(sends);
        bus.in_vld = 1; bus.in_data = 14'h3AA;
        tick();
        bus.in_vld = 0;
        bus.b_a_1 = 1; bus.b_a_0 = 4'd2;
        tick();
        bus.b_a_1 = 0; bus.b_a_0 = 4'd0;
        total++; if (bus.credit_cnt !== 4'd2) begin bad++; $display("FAIL flush_pre got=%0d exp=2", bus.credit_cnt); end
        rst = 1; bus.b_a_1 = 1; bus.b_a_0 = 4'd4;
        tick();
        rst = 0; bus.b_a_1 = 0; bus.b_a_0 = 4'd0;
        total++; if (bus.a_b_1 !== 1'b0 || bus.in_rdy !== 1'b1 || bus.credit_cnt !== 4'd8 || bus.cr_err !== 1'b0) begin
            bad++; $display("FAIL flush_state got=%b/%b/%0d/%b exp=0/1/8/0",
                            bus.a_b_1, bus.in_rdy, bus.credit_cnt, bus.cr_err);
        end
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            stale += int'(bus.a_b_1);
        end
        total++; if (stale != 0) begin bad++; $display("FAIL flush_stale got=%0d exp=0", stale); end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            bus.in_vld  = ($urandom_range(0, 3) != 0);
            bus.in_data = 14'($urandom);
            bus.b_a_1   = ($urandom_range(0, 2) == 0);
            bus.b_a_0   = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            tick();
            total++;
            if (bus.a_b_1 !== m_ab1 || bus.a_b_0 !== m_ab0 || bus.credit_cnt !== 4'(m_cred)
                || bus.cr_err !== m_err || bus.in_rdy !== (m_fifo.size() != DEPTH)) begin
                bad++;
                if (errs < 10) begin
                    $display("FAIL random cyc=%0d got=%b/%h/%0d/%b/%b exp=%b/%h/%0d/%b/%b", i,
                             bus.a_b_1, bus.a_b_0, bus.credit_cnt, bus.cr_err, bus.in_rdy,
                             m_ab1, m_ab0, m_cred, m_err, m_fifo.size() != DEPTH);
                end
                errs++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_credit_return();
        test_simul_send_return();
        test_overflow();
        test_reset_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
